slt_exec_unit: RTL and testbench
================================

Name: slt_exec_unit

Overview:
- Handshaked set-less-than execution unit for the 16-bit CPU datapath.
- Acts as the responder to the issue stage. It accepts compare requests (SLT, SLTU, SLTI, SLTIU), computes a 16-bit result of 0 or 1, and returns it through a small output buffer with valid/ready flow control.
- Replaces direct combinational SLTI use at the execute stage. This lets writeback stall without losing results.

Parameters:
- DEPTH, 2, output buffer entries (power of 2, minimum 2).
- TAG_W, 3, width of the request tag carried through to the response.
- IMM_W, 6, immediate field width for SLTI/SLTIU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  2  00=SLT, 01=SLTU, 10=SLTI, 11=SLTIU.
- req_a  in  16  rs operand.
- req_b  in  16  rt operand; ignored for immediate ops.
- req_imm  in  IMM_W  immediate; ignored for register ops.
- req_tag  in  TAG_W  destination/ordering tag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  result, 16'd1 or 16'd0.
- rsp_tag  out  TAG_W  tag of the request that produced rsp_data.

Behaviour:
- Clocking and reset:
  - One clock domain; clk and rst_n, with reset asynchronous and active-low.
  - On reset: rsp_valid=0, rsp_data=0, rsp_tag=0, buffer empty, req_ready=1 one cycle after rst_n deasserts.
- Handshake:
  - A request transfers when req_valid & req_ready at a clk edge.
  - A response transfers when rsp_valid & rsp_ready at a clk edge.
  - Once rsp_valid is asserted, rsp_data and rsp_tag stay stable until the response transfers.
- Operand B selection:
  - SLT/SLTU: B = req_b.
  - SLTI: B = req_imm sign-extended to 16 bits.
  - SLTIU: B = req_imm zero-extended to 16 bits.
- Compare:
  - SLT/SLTI compare signed two's complement.
  - SLTU/SLTIU compare unsigned.
  - rsp_data = {15'b0, A<B}. Equal operands give 0.
- Latency: exactly 1 cycle. A request accepted at edge N appears at rsp_valid after edge N, when the buffer was empty.
- Output buffer:
  - FIFO of DEPTH entries, each holding {tag, result bit}.
  - Head entry drives rsp_*. Read/write pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits.
- Full and empty:
  - req_ready = !full | (rsp_valid & rsp_ready). Accepting into a full buffer is allowed only on the same cycle it is popped.
  - rsp_valid = !empty.
- Simultaneous push and pop: occupancy unchanged and both pointers advance.
- Order: responses leave strictly in acceptance order.
- Reset mid-operation: all buffered results are discarded and no response is produced for them.
- Illegal input: req_valid with X-free inputs is required. No error state exists.

Optional Feature:
- Macro: SLT_EXEC_STATS_EN.
- When defined:
  - Adds output ports stat_issued [15:0] and stat_true [15:0].
  - stat_issued counts accepted requests; stat_true counts accepted requests whose result was 1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package slt_exec_pkg:
  - op enum (OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU).
  - Localparam DATA_W=16.
  - Function slt_eval(op, a, b, imm) returning the result bit.
- One sub-module, slt_result_fifo: parameterised DEPTH/width synchronous FIFO with push/pop/full/empty, using the same clk/rst_n reset style.
- The top level holds operand selection, the compare, the handshake glue and the optional stats.

Test Plan:
- SLT, a=3, b=5 → one cycle later rsp_valid=1, rsp_data=1. Then SLT, a=7, b=7 → rsp_data=0.
- SLT vs SLTU with a=16'hFFFF, b=16'd1 → SLT gives 1, SLTU gives 0, tags returned in order (tags 1 then 2).
- SLTI a=16'hFFFE, imm=6'h3F (-1) → 1. SLTIU a=16'd62, imm=6'h3F (63) → 1. SLTIU a=16'd63, imm=6'h3F → 0.
- Backpressure:
  - Hold rsp_ready=0 and issue 3 requests → 2 accepted, req_ready=0 on the third, rsp_data held stable.
  - Raise rsp_ready → the third is accepted on the same edge as the first pop, and all 3 results drain in order.
- Reset mid-operation: fill the buffer, then pulse rst_n low asynchronously mid-cycle → rsp_valid drops immediately and no stale response appears after release. With SLT_EXEC_STATS_EN, the counters read 0.
- Stats (SLT_EXEC_STATS_EN): 10 requests, 4 with true results → stat_issued=10, stat_true=4. Force stat_issued to 16'hFFFF, then 1 more request → it stays at 16'hFFFF.

Source files
------------

// File: rtl/slt_exec_pkg.sv
// ---------------------------------------------------------------------------
// slt_exec_pkg
//
// Shared definitions for the set-less-than execution unit.
//   - slt_op_e  : request opcode encoding (SLT, SLTU, SLTI, SLTIU)
//   - DATA_W    : datapath width of the 16-bit CPU
//   - slt_eval  : evaluates one compare and returns the single result bit
//
// No ports; imported by slt_result_fifo and slt_exec_unit.
// ---------------------------------------------------------------------------
package slt_exec_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_SLT   = 2'b00,
        OP_SLTU  = 2'b01,
        OP_SLTI  = 2'b10,
        OP_SLTIU = 2'b11
    } slt_op_e;

    // The caller hands in the immediate already widened to DATA_W, because the
    // kind of widening (sign or zero) depends on the opcode and on the
    // immediate width, which only the instantiating module knows. This
    // function picks the second operand and the signedness of the compare.
    function automatic logic slt_eval(
        input slt_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] opB;
        logic              isSigned;
        logic              lessThan;
        opB      = ((op == OP_SLTI) || (op == OP_SLTIU)) ? imm : b;
        isSigned = (op == OP_SLT) || (op == OP_SLTI);
        if (isSigned) begin
            lessThan = ($signed(a) < $signed(opB));
        end else begin
            lessThan = (a < opB);
        end
        return lessThan;
    endfunction

endpackage

// File: rtl/slt_result_fifo.sv
// ---------------------------------------------------------------------------
// slt_result_fifo
//
// Small synchronous FIFO that buffers finished compare results so the
// consumer can stall without losing anything.
//
// Parameters:
//   DEPTH  number of entries (power of 2, at least 2)
//   WIDTH  bits per entry
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset; empties the FIFO
//   push_i   in   write wdata_i this cycle
//   pop_i    in   discard the head entry this cycle
//   wdata_i  in   entry to write
//   rdata_o  out  head entry (meaningful while empty_o is low)
//   full_o   out  all DEPTH entries occupied
//   empty_o  out  no entries occupied
//
// A push while full is taken only if a pop happens on the same edge, which
// frees the slot being written behind the head.
// ---------------------------------------------------------------------------
module slt_result_fifo
    import slt_exec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Status flags come straight from the occupancy counter so full and
    // empty never disagree with the pointers.
    always_comb begin
        full_o  = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == '0);
        rdata_o = mem_q[rdPtr_q];
    end

    // Qualify the requests: never pop an empty FIFO, and only write into a
    // full one when the head is leaving on the same edge.
    always_comb begin
        doPop  = pop_i && !empty_o;
        doPush = push_i && (!full_o || doPop);
    end

    // Next-state for pointers and occupancy. Pointers are exactly PTR_W bits
    // wide, so incrementing wraps modulo DEPTH for free. A simultaneous push
    // and pop leaves the occupancy unchanged while both pointers advance.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers. The storage is cleared on reset so the
    // head reads as zero while the FIFO is empty after reset, which keeps
    // the response outputs at zero until the first result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/slt_exec_unit.sv
// ---------------------------------------------------------------------------
// slt_exec_unit
//
// Handshaked set-less-than execution unit for the 16-bit datapath. Accepts
// SLT / SLTU / SLTI / SLTIU requests from issue, computes a 0/1 result and
// returns it with its tag through a DEPTH-entry buffer, so writeback can
// stall without dropping results. Results leave in acceptance order, and an
// accepted request is visible on the response side one clock later when the
// buffer was empty.
//
// Parameters:
//   DEPTH  output buffer entries (power of 2, at least 2)
//   TAG_W  width of the tag carried from request to response
//   IMM_W  immediate width for SLTI / SLTIU (less than 16)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset; discards buffered results
//   req_valid    in   request present
//   req_ready    out  unit accepts a request this cycle
//   req_op       in   00 SLT, 01 SLTU, 10 SLTI, 11 SLTIU
//   req_a        in   rs operand
//   req_b        in   rt operand (register ops only)
//   req_imm      in   immediate (immediate ops only)
//   req_tag      in   destination / ordering tag
//   rsp_valid    out  result available
//   rsp_ready    in   consumer takes the result this cycle
//   rsp_data     out  16'd1 or 16'd0
//   rsp_tag      out  tag of the request that produced rsp_data
//
// Build option SLT_EXEC_STATS_EN adds:
//   stat_issued  out  saturating count of accepted requests
//   stat_true    out  saturating count of accepted requests with result 1
// ---------------------------------------------------------------------------
module slt_exec_unit
    import slt_exec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 3,
    parameter int IMM_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [IMM_W-1:0]  req_imm,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef SLT_EXEC_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_true
`endif
);

    localparam int ENTRY_W = TAG_W + 1;

    slt_op_e           opSel;
    logic [DATA_W-1:0] immExt;
    logic              resultBit;
    logic              pushReq;
    logic              popRsp;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [ENTRY_W-1:0] headEntry;
    logic              readyEn_q;

    // Widen the immediate according to the opcode: SLTI treats it as a
    // signed value, everything else as unsigned. For register ops the
    // widened immediate is ignored by slt_eval.
    always_comb begin
        opSel = slt_op_e'(req_op);
        if (opSel == OP_SLTI) begin
            immExt = {{(DATA_W-IMM_W){req_imm[IMM_W-1]}}, req_imm};
        end else begin
            immExt = {{(DATA_W-IMM_W){1'b0}}, req_imm};
        end
        resultBit = slt_eval(opSel, req_a, req_b, immExt);
    end

    // Hold off accepting requests until the first clock after reset is
    // released, so nothing is taken while the buffer is still coming out of
    // reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    // Handshake glue. A full buffer can still accept when the consumer is
    // taking the head on the same edge, so a stalled pipeline restarts
    // without a bubble.
    always_comb begin
        rsp_valid = !fifoEmpty;
        popRsp    = rsp_valid && rsp_ready;
        req_ready = readyEn_q && (!fifoFull || popRsp);
        pushReq   = req_valid && req_ready;
        rsp_data  = {{(DATA_W-1){1'b0}}, headEntry[0]};
        rsp_tag   = headEntry[ENTRY_W-1:1];
    end

    slt_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushReq),
        .pop_i   (popRsp),
        .wdata_i ({req_tag, resultBit}),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

`ifdef SLT_EXEC_STATS_EN
    logic [15:0] statIssued_q, statIssued_d;
    logic [15:0] statTrue_q, statTrue_d;

    // Counters stick at all-ones instead of wrapping, so a long run never
    // reports a misleadingly small number.
    always_comb begin
        statIssued_d = statIssued_q;
        statTrue_d   = statTrue_q;
        if (pushReq) begin
            if (statIssued_q != 16'hFFFF) begin
                statIssued_d = statIssued_q + 16'd1;
            end
            if (resultBit && (statTrue_q != 16'hFFFF)) begin
                statTrue_d = statTrue_q + 16'd1;
            end
        end
    end

    // Statistic registers, cleared with the rest of the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statIssued_q <= '0;
            statTrue_q   <= '0;
        end else begin
            statIssued_q <= statIssued_d;
            statTrue_q   <= statTrue_d;
        end
    end

    assign stat_issued = statIssued_q;
    assign stat_true   = statTrue_q;
`endif

endmodule

// File: tb/tb_slt_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_slt_exec_unit
//
// Directed bench for slt_exec_unit. A queue-based reference model tracks the
// expected buffer contents from plain integer arithmetic; a negedge process
// checks the DUT against it every cycle, and the directed sequence adds
// hand-computed literal checks. Define SLT_EXEC_STATS_EN to also exercise
// the statistics counters.
// ---------------------------------------------------------------------------
module tb_slt_exec_unit;

    localparam int DEPTH = 2;
    localparam int TAG_W = 3;
    localparam int IMM_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'd0;
    logic [15:0]       req_a = 16'd0;
    logic [15:0]       req_b = 16'd0;
    logic [IMM_W-1:0]  req_imm = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [15:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
`ifdef SLT_EXEC_STATS_EN
    logic [15:0]       stat_issued;
    logic [15:0]       stat_true;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [TAG_W:0] expQ[$];
    logic           modelReady = 1'b0;
    logic [15:0]    modelIssued = 16'd0;
    logic [15:0]    modelTrue = 16'd0;
    logic           satPending = 1'b0;

    slt_exec_unit #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .IMM_W (IMM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_imm   (req_imm),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
`ifdef SLT_EXEC_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_true   (stat_true)
`endif
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Expected compare result computed with plain integer arithmetic
    function automatic logic expectedBit(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [IMM_W-1:0] imm);
        int ua, ub, sa, sb, iu, is;
        ua = a;
        ub = b;
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        iu = imm;
        is = imm[IMM_W-1] ? iu - (1 << IMM_W) : iu;
        case (op)
            2'd0:    return sa < sb;
            2'd1:    return ua < ub;
            2'd2:    return sa < is;
            default: return ua < iu;
        endcase
    endfunction

    // Record one accepted request in the model
    task automatic modelAccept();
        logic bitVal;
        bitVal = expectedBit(req_op, req_a, req_b, req_imm);
        expQ.push_back({req_tag, bitVal});
        if (modelIssued != 16'hFFFF) modelIssued <= modelIssued + 16'd1;
        if (bitVal && modelTrue != 16'hFFFF) modelTrue <= modelTrue + 16'd1;
    endtask

    // Model update: pop on a response transfer, push on a request transfer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            modelReady  <= 1'b0;
            modelIssued <= 16'd0;
            modelTrue   <= 16'd0;
        end else begin
            modelReady <= 1'b1;
            if (satPending) modelIssued <= 16'hFFFF;
            if (expQ.size() > 0 && rsp_ready) begin
                if (req_valid && modelReady) modelAccept();
                void'(expQ.pop_front());
            end else if (req_valid && modelReady && expQ.size() < DEPTH) begin
                modelAccept();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'd0);
            checkOutput("rst_rsp_data", rsp_data, 16'd0);
        end else begin
            checkOutput("cyc_rsp_valid", 16'(rsp_valid), 16'(expQ.size() > 0));
            checkOutput("cyc_req_ready", 16'(req_ready),
                        16'(modelReady && (expQ.size() < DEPTH || (expQ.size() > 0 && rsp_ready))));
            if (expQ.size() > 0) begin
                checkOutput("cyc_rsp_data", rsp_data, 16'(expQ[0][0]));
                checkOutput("cyc_rsp_tag", 16'(rsp_tag), 16'(expQ[0][TAG_W:1]));
            end
`ifdef SLT_EXEC_STATS_EN
            if (!satPending) checkOutput("cyc_stat_issued", stat_issued, modelIssued);
            checkOutput("cyc_stat_true", stat_true, modelTrue);
`endif
        end
    end

    // Present one request and hold it until accepted (bounded wait).
    // Entered and left 2 time units after a rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [IMM_W-1:0] imm, input logic [TAG_W-1:0] tag);
        logic acc;
        int   waitCycles;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_imm   = imm;
        req_tag   = tag;
        req_valid = 1'b1;
        acc        = 1'b0;
        waitCycles = 0;
        while (!acc && waitCycles < 20) begin
            #1;
            acc = req_ready;
            @(posedge clk);
            #2;
            waitCycles++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: req_ready stayed 0, required 1 within 20 cycles");
        end
    endtask

    logic [1:0]       statOp  [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0]      statA   [10] = '{16'd1, 16'd2, 16'd0, 16'd5, 16'd10, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'd4};
    logic [15:0]      statB   [10] = '{16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4};
    logic [IMM_W-1:0] statImm [10] = '{6'd0, 6'd0, 6'd0, 6'd6, 6'd3, 6'd0, 6'd0, 6'h3F, 6'd1, 6'd0};

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("ready_after_reset", 16'(req_ready), 16'd1);
        checkOutput("valid_after_reset", 16'(rsp_valid), 16'd0);
        checkOutput("tag_after_reset", 16'(rsp_tag), 16'd0);

        // Basic signed compare, one-cycle latency
        applyStimulus(2'd0, 16'd3, 16'd5, '0, 3'd0);
        checkOutput("slt_3_5_valid", 16'(rsp_valid), 16'd1);
        checkOutput("slt_3_5_data", rsp_data, 16'd1);
        applyStimulus(2'd0, 16'd7, 16'd7, '0, 3'd1);
        checkOutput("slt_7_7_data", rsp_data, 16'd0);
        checkOutput("slt_7_7_tag", 16'(rsp_tag), 16'd1);
        @(posedge clk); #2;
        checkOutput("drained_1", 16'(rsp_valid), 16'd0);

        // Signed versus unsigned, in order, with the consumer stalled
        rsp_ready = 1'b0;
        applyStimulus(2'd0, 16'hFFFF, 16'd1, '0, 3'd1);
        applyStimulus(2'd1, 16'hFFFF, 16'd1, '0, 3'd2);
        checkOutput("slt_neg_data", rsp_data, 16'd1);
        checkOutput("slt_neg_tag", 16'(rsp_tag), 16'd1);
        checkOutput("full_ready", 16'(req_ready), 16'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        checkOutput("sltu_neg_data", rsp_data, 16'd0);
        checkOutput("sltu_neg_tag", 16'(rsp_tag), 16'd2);
        @(posedge clk); #2;
        checkOutput("drained_2", 16'(rsp_valid), 16'd0);

        // Immediate forms and the equal-operand boundary
        applyStimulus(2'd2, 16'hFFFE, '0, 6'h3F, 3'd3);
        checkOutput("slti_m2_m1", rsp_data, 16'd1);
        applyStimulus(2'd3, 16'd62, '0, 6'h3F, 3'd4);
        checkOutput("sltiu_62_63", rsp_data, 16'd1);
        applyStimulus(2'd3, 16'd63, '0, 6'h3F, 3'd5);
        checkOutput("sltiu_63_63", rsp_data, 16'd0);
        checkOutput("sltiu_63_63_tag", 16'(rsp_tag), 16'd5);
        @(posedge clk); #2;

        // Backpressure: third request waits, then enters on the first pop
        rsp_ready = 1'b0;
        req_op = 2'd0; req_a = 16'd1; req_b = 16'd2; req_tag = 3'd6; req_valid = 1'b1;
        @(posedge clk); #2;
        req_op = 2'd1; req_a = 16'd5; req_b = 16'd2; req_tag = 3'd7;
        @(posedge clk); #2;
        req_op = 2'd2; req_a = 16'd0; req_imm = 6'd1; req_tag = 3'd0;
        #1;
        checkOutput("bp_third_blocked", 16'(req_ready), 16'd0);
        @(posedge clk); #2;
        checkOutput("bp_hold_tag", 16'(rsp_tag), 16'd6);
        checkOutput("bp_hold_data", rsp_data, 16'd1);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_ready_on_pop", 16'(req_ready), 16'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        checkOutput("bp_second_tag", 16'(rsp_tag), 16'd7);
        checkOutput("bp_second_data", rsp_data, 16'd0);
        @(posedge clk); #2;
        checkOutput("bp_third_tag", 16'(rsp_tag), 16'd0);
        checkOutput("bp_third_data", rsp_data, 16'd1);
        @(posedge clk); #2;
        checkOutput("bp_drained", 16'(rsp_valid), 16'd0);

        // Asynchronous reset with a full buffer
        rsp_ready = 1'b0;
        applyStimulus(2'd0, 16'd1, 16'd2, '0, 3'd1);
        applyStimulus(2'd1, 16'd2, 16'd1, '0, 3'd2);
        checkOutput("pre_reset_valid", 16'(rsp_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_valid", 16'(rsp_valid), 16'd0);
        checkOutput("mid_reset_data", rsp_data, 16'd0);
        checkOutput("mid_reset_tag", 16'(rsp_tag), 16'd0);
`ifdef SLT_EXEC_STATS_EN
        checkOutput("mid_reset_issued", stat_issued, 16'd0);
        checkOutput("mid_reset_true", stat_true, 16'd0);
`endif
        #4;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        checkOutput("post_reset_valid", 16'(rsp_valid), 16'd0);
        checkOutput("post_reset_ready", 16'(req_ready), 16'd1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("no_stale_rsp", 16'(rsp_valid), 16'd0);

`ifdef SLT_EXEC_STATS_EN
        // Ten requests, four true, then saturation of the issue counter
        for (int i = 0; i < 10; i++) begin
            applyStimulus(statOp[i], statA[i], statB[i], statImm[i], 3'(i));
        end
        checkOutput("stat_issued_10", stat_issued, 16'd10);
        checkOutput("stat_true_4", stat_true, 16'd4);
        satPending = 1'b1;
        force dut.statIssued_q = 16'hFFFF;
        @(posedge clk); #2;
        release dut.statIssued_q;
        satPending = 1'b0;
        applyStimulus(2'd0, 16'd9, 16'd2, '0, 3'd3);
        checkOutput("stat_issued_sat", stat_issued, 16'hFFFF);
        checkOutput("stat_true_after_sat", stat_true, 16'd4);
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
